// File: rtl/pipe_hazard_scoreboard_if.sv
// ----------------------------------------------------------------------------
// pipe_hazard_scoreboard_if
// Bundle between the ID stage and the hazard/forwarding scoreboard.
// The ID stage (master) presents the decoded instruction and the pipeline
// control requests. The scoreboard (slave) answers with stall, forward
// selects, issue and the stall-cycle counter.
// ----------------------------------------------------------------------------
interface pipe_hazard_scoreboard_if #(
    parameter int REG_AW = 5,
    parameter int SEL_W  = 2
);
    logic              id_valid;
    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic              id_use_rs;
    logic              id_use_rt;
    logic [REG_AW-1:0] id_dst;
    logic              id_we;
    logic              id_is_load;
    logic              id_is_branch;
    logic              flush;
    logic              ext_hold;
    logic              stall;
    logic [SEL_W-1:0]  fwd_sel_a;
    logic [SEL_W-1:0]  fwd_sel_b;
    logic              issue;
    logic [31:0]       stall_cnt;

    modport master (
        output id_valid, id_rs, id_rt, id_use_rs, id_use_rt,
        output id_dst, id_we, id_is_load, id_is_branch, flush, ext_hold,
        input  stall, fwd_sel_a, fwd_sel_b, issue, stall_cnt
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt,
        input  id_dst, id_we, id_is_load, id_is_branch, flush, ext_hold,
        output stall, fwd_sel_a, fwd_sel_b, issue, stall_cnt
    );
endinterface

// File: rtl/pipe_hazard_scoreboard.sv
// ----------------------------------------------------------------------------
// pipe_hazard_scoreboard
// Registered scoreboard of in-flight destination registers for the NSTAGE
// slots after ID (slot 1 = EXE ... slot NSTAGE = WB). Every cycle it compares
// the ID-stage sources against the tracked producers and decides whether the
// operand can be forwarded (and from which slot) or whether ID must stall.
//
// Stall, issue and forward selects are combinational (zero latency). All of
// them are forced to zero while the synchronous active-low reset is low.
//
// Optional feature macro: HAZ_STALL_CNT_EN
//   defined   -> saturating 32-bit count of non-held stall cycles
//   undefined -> stall_cnt tied to zero, no counter register
// ----------------------------------------------------------------------------
module pipe_hazard_scoreboard #(
    parameter int REG_AW     = 5,
    parameter int NSTAGE     = 3,
    parameter int ALU_AVAIL  = 1,
    parameter int LOAD_AVAIL = 2,
    parameter int BR_EXTRA   = 1,
    parameter int SEL_W      = 2
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    pipe_hazard_scoreboard_if.slave      io_hz
);

    // Width of the stored availability slot; 4 bits covers every legal
    // combination of slot numbers for NSTAGE up to 7.
    localparam int AV_W = 4;

    localparam logic [AV_W-1:0]   ALU_AV  = AV_W'(ALU_AVAIL);
    localparam logic [AV_W-1:0]   LD_AV   = AV_W'(LOAD_AVAIL);
    localparam logic [REG_AW-1:0] REG_ZERO = {REG_AW{1'b0}};
    localparam logic [SEL_W-1:0]  SEL_RF   = {SEL_W{1'b0}};

    // ------------------------------------------------------------------
    // Scoreboard slots 1..NSTAGE
    // ------------------------------------------------------------------
    logic              r_v     [1:NSTAGE];
    logic [REG_AW-1:0] r_dst   [1:NSTAGE];
    logic              r_we    [1:NSTAGE];
    logic [AV_W-1:0]   r_avail [1:NSTAGE];

    // ------------------------------------------------------------------
    // Combinational decision signals
    // ------------------------------------------------------------------
    logic [31:0]       w_br_extra;
    logic [NSTAGE:1]   w_rdy;
    logic [NSTAGE:1]   w_match_a;
    logic [NSTAGE:1]   w_match_b;
    logic [SEL_W:0]    w_pick_a;
    logic [SEL_W:0]    w_pick_b;
    logic              w_hit_a;
    logic              w_hit_b;
    logic              w_hz_a;
    logic              w_hz_b;
    logic [SEL_W-1:0]  w_sel_a;
    logic [SEL_W-1:0]  w_sel_b;
    logic              w_stall;
    logic              w_issue;
    logic [AV_W-1:0]   w_new_avail;
    logic              w_new_we;

    // Youngest (lowest-numbered) matching slot wins. Returns {ready, slot};
    // both are zero when nothing matches.
    function automatic logic [SEL_W:0] pick_youngest(
        input logic [NSTAGE:1] match,
        input logic [NSTAGE:1] rdy
    );
        logic [SEL_W-1:0] slot;
        logic             ok;
        slot = {SEL_W{1'b0}};
        ok   = 1'b0;
        for (int s = NSTAGE; s >= 1; s--) begin
            slot = match[s] ? SEL_W'(s) : slot;
            ok   = match[s] ? rdy[s]    : ok;
        end
        return {ok, slot};
    endfunction

    // Per-slot readiness: the producer in slot s can feed this consumer
    // when s has reached its availability slot plus the branch penalty.
    always_comb begin
        w_br_extra = io_hz.id_is_branch ? 32'(BR_EXTRA) : 32'd0;
        w_rdy      = {NSTAGE{1'b0}};
        for (int s = 1; s <= NSTAGE; s++) begin
            w_rdy[s] = (32'(s) >= (32'(r_avail[s]) + w_br_extra));
        end
    end

    // Per-slot source matches; register 0 and unused sources never match.
    always_comb begin
        w_match_a = {NSTAGE{1'b0}};
        w_match_b = {NSTAGE{1'b0}};
        for (int s = 1; s <= NSTAGE; s++) begin
            w_match_a[s] = r_v[s] && r_we[s] && io_hz.id_use_rs &&
                           (io_hz.id_rs != REG_ZERO) && (r_dst[s] == io_hz.id_rs);
            w_match_b[s] = r_v[s] && r_we[s] && io_hz.id_use_rt &&
                           (io_hz.id_rt != REG_ZERO) && (r_dst[s] == io_hz.id_rt);
        end
    end

    // Winner selection, hazard detection and the top-level stall/issue.
    always_comb begin
        w_pick_a = pick_youngest(w_match_a, w_rdy);
        w_pick_b = pick_youngest(w_match_b, w_rdy);
        w_hit_a  = |w_match_a;
        w_hit_b  = |w_match_b;
        w_hz_a   = w_hit_a && !w_pick_a[SEL_W];
        w_hz_b   = w_hit_b && !w_pick_b[SEL_W];
        w_sel_a  = (w_hit_a && w_pick_a[SEL_W]) ? w_pick_a[SEL_W-1:0] : SEL_RF;
        w_sel_b  = (w_hit_b && w_pick_b[SEL_W]) ? w_pick_b[SEL_W-1:0] : SEL_RF;
        // Flush beats stall; hold only blocks issue, it does not hide a stall.
        w_stall  = i_rst && io_hz.id_valid && !io_hz.flush && (w_hz_a || w_hz_b);
        w_issue  = i_rst && io_hz.id_valid && !io_hz.flush && !w_stall &&
                   !io_hz.ext_hold;
    end

    // Fields of the entry that enters slot 1 when the ID instruction issues.
    always_comb begin
        w_new_avail = io_hz.id_is_load ? LD_AV : ALU_AV;
        w_new_we    = io_hz.id_we && (io_hz.id_dst != REG_ZERO);
    end

    assign io_hz.stall     = w_stall;
    assign io_hz.issue     = w_issue;
    assign io_hz.fwd_sel_a = i_rst ? w_sel_a : SEL_RF;
    assign io_hz.fwd_sel_b = i_rst ? w_sel_b : SEL_RF;

    // Scoreboard update: clear on reset, freeze on hold, otherwise shift one
    // slot toward WB and load slot 1 with the issued instruction or a bubble.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            for (int s = 1; s <= NSTAGE; s++) begin
                r_v[s]     <= 1'b0;
                r_dst[s]   <= REG_ZERO;
                r_we[s]    <= 1'b0;
                r_avail[s] <= {AV_W{1'b0}};
            end
        end else if (io_hz.ext_hold) begin
            for (int s = 1; s <= NSTAGE; s++) begin
                r_v[s]     <= r_v[s];
                r_dst[s]   <= r_dst[s];
                r_we[s]    <= r_we[s];
                r_avail[s] <= r_avail[s];
            end
        end else begin
            for (int s = NSTAGE; s >= 2; s--) begin
                r_v[s]     <= r_v[s-1];
                r_dst[s]   <= r_dst[s-1];
                r_we[s]    <= r_we[s-1];
                r_avail[s] <= r_avail[s-1];
            end
            r_v[1]     <= w_issue;
            r_dst[1]   <= w_issue ? io_hz.id_dst : REG_ZERO;
            r_we[1]    <= w_issue && w_new_we;
            r_avail[1] <= w_issue ? w_new_avail : {AV_W{1'b0}};
        end
    end

`ifdef HAZ_STALL_CNT_EN
    logic [31:0] r_stall_cnt;

    // Saturating count of stall cycles that were not frozen by ext_hold.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_stall_cnt <= 32'h0000_0000;
        end else if (w_stall && !io_hz.ext_hold && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end else begin
            r_stall_cnt <= r_stall_cnt;
        end
    end

    assign io_hz.stall_cnt = i_rst ? r_stall_cnt : 32'h0000_0000;
`else
    assign io_hz.stall_cnt = 32'h0000_0000;
`endif

endmodule

// File: tb/tb_pipe_hazard_scoreboard.sv
// ----------------------------------------------------------------------------
// tb_pipe_hazard_scoreboard
// Table-driven bench: each record is one ID-stage cycle with the outputs the
// scoreboard must show in that cycle. Records are pushed onto an expectation
// queue when driven and popped/compared on the falling edge.
// ----------------------------------------------------------------------------
module tb_pipe_hazard_scoreboard;

    typedef struct {
        logic       rst;
        logic       v;
        logic [4:0] rs;
        logic       urs;
        logic [4:0] rt;
        logic       urt;
        logic [4:0] dst;
        logic       we;
        logic       ld;
        logic       br;
        logic       fl;
        logic       hd;
        logic       est;
        logic       eis;
        logic [1:0] esa;
        logic [1:0] esb;
        logic       cs;     // forward selects are checked only when set
    } vec_t;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    int   vec_no;
    logic [31:0] ref_cnt;
    vec_t exp_q [$];
    vec_t tbl   [$];

    pipe_hazard_scoreboard_if #(.REG_AW(5), .SEL_W(2)) bus ();

    pipe_hazard_scoreboard #(
        .REG_AW(5), .NSTAGE(3), .ALU_AVAIL(1), .LOAD_AVAIL(2),
        .BR_EXTRA(1), .SEL_W(2)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .io_hz (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(int r, int v, int rs, int urs, int rt, int urt,
                                int dst, int we, int ld, int br, int fl, int hd,
                                int est, int eis, int esa, int esb, int cs);
        vec_t x;
        x.rst = 1'(r);   x.v   = 1'(v);
        x.rs  = 5'(rs);  x.urs = 1'(urs);
        x.rt  = 5'(rt);  x.urt = 1'(urt);
        x.dst = 5'(dst); x.we  = 1'(we);
        x.ld  = 1'(ld);  x.br  = 1'(br);
        x.fl  = 1'(fl);  x.hd  = 1'(hd);
        x.est = 1'(est); x.eis = 1'(eis);
        x.esa = 2'(esa); x.esb = 2'(esb);
        x.cs  = 1'(cs);
        return x;
    endfunction

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s vec=%0d actual=%0h expected=%0h", name, vec_no, act, exp);
        end
    endtask

    task automatic check_one();
        vec_t e;
        logic [31:0] exp_cnt;
        e = exp_q.pop_front();
`ifdef HAZ_STALL_CNT_EN
        exp_cnt = e.rst ? ref_cnt : 32'h0;
`else
        exp_cnt = 32'h0;
`endif
        cmp("stall", 32'(bus.stall), 32'(e.est));
        cmp("issue", 32'(bus.issue), 32'(e.eis));
        if (e.cs) begin
            cmp("fwd_sel_a", 32'(bus.fwd_sel_a), 32'(e.esa));
            cmp("fwd_sel_b", 32'(bus.fwd_sel_b), 32'(e.esb));
        end
        cmp("stall_cnt", bus.stall_cnt, exp_cnt);
        // Reference counter for the coming edge.
        if (!e.rst)
            ref_cnt = 32'h0;
        else if (e.est && !e.hd && ref_cnt != 32'hFFFF_FFFF)
            ref_cnt = ref_cnt + 32'd1;
        vec_no++;
    endtask

    task automatic apply(input vec_t x);
        @(posedge clk);
        #1;
        rst                = x.rst;
        bus.id_valid       = x.v;
        bus.id_rs          = x.rs;
        bus.id_use_rs      = x.urs;
        bus.id_rt          = x.rt;
        bus.id_use_rt      = x.urt;
        bus.id_dst         = x.dst;
        bus.id_we          = x.we;
        bus.id_is_load     = x.ld;
        bus.id_is_branch   = x.br;
        bus.flush          = x.fl;
        bus.ext_hold       = x.hd;
        exp_q.push_back(x);
        @(negedge clk);
        check_one();
    endtask

    // Watchdog so the run always terminates.
    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        total = 0; bad = 0; vec_no = 0; ref_cnt = 32'h0;
        rst = 1'b0;
        bus.id_valid = 1'b0; bus.id_rs = 5'd0; bus.id_rt = 5'd0;
        bus.id_use_rs = 1'b0; bus.id_use_rt = 1'b0; bus.id_dst = 5'd0;
        bus.id_we = 1'b0; bus.id_is_load = 1'b0; bus.id_is_branch = 1'b0;
        bus.flush = 1'b0; bus.ext_hold = 1'b0;

        //                 rst v rs u rt u dst we ld br fl hd  st is sa sb cs
        // reset: outputs forced low even with a valid instruction
        tbl.push_back(mk(0, 1, 3, 1, 5, 1, 3, 1, 0, 0, 0, 0,  0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1));
        // ALU back-to-back forwarding from slots 1, 2, 3 then RF
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0,  0, 1, 0, 0, 1));
        tbl.push_back(mk(1, 1, 3, 1, 0, 0, 8, 1, 0, 0, 0, 0,  0, 1, 1, 0, 1));
        tbl.push_back(mk(1, 1, 3, 1, 8, 1, 0, 0, 0, 0, 0, 0,  0, 1, 2, 1, 1));
        tbl.push_back(mk(1, 1, 3, 1, 8, 1, 0, 0, 0, 0, 0, 0,  0, 1, 3, 2, 1));
        tbl.push_back(mk(1, 1, 3, 1, 8, 1, 0, 0, 0, 0, 0, 0,  0, 1, 0, 3, 1));
        // load-use: one stall, then forward from slot 2
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 5, 1, 1, 0, 0, 0,  0, 1, 0, 0, 1));
        tbl.push_back(mk(1, 1, 0, 0, 5, 1, 9, 1, 0, 0, 0, 0,  1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 0, 5, 1, 9, 1, 0, 0, 0, 0,  0, 1, 0, 2, 1));
        // branch after ALU: one stall, then slot 2 (rt=$0 read is ignored)
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 4, 1, 0, 0, 0, 0,  0, 1, 0, 0, 1));
        tbl.push_back(mk(1, 1, 4, 1, 0, 1, 0, 0, 0, 1, 0, 0,  1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 4, 1, 0, 1, 0, 0, 0, 1, 0, 0,  0, 1, 2, 0, 1));
        // branch after load: two stalls, then slot 3
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 4, 1, 1, 0, 0, 0,  0, 1, 0, 0, 1));
        tbl.push_back(mk(1, 1, 4, 1, 0, 0, 0, 0, 0, 1, 0, 0,  1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 4, 1, 0, 0, 0, 0, 0, 1, 0, 0,  1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 4, 1, 0, 0, 0, 0, 0, 1, 0, 0,  0, 1, 3, 0, 1));
        // youngest of two $7 writers wins; load writing $0 is not tracked
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0,  0, 1, 0, 0, 1));
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0,  0, 1, 0, 0, 1));
        tbl.push_back(mk(1, 1, 7, 1, 7, 1, 0, 1, 1, 0, 0, 0,  0, 1, 1, 1, 1));
        tbl.push_back(mk(1, 1, 0, 1, 0, 1, 0, 0, 0, 1, 0, 0,  0, 1, 0, 0, 1));
        // flush during a pending load-use stall: no stall, no issue, bubble
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 6, 1, 1, 0, 0, 0,  0, 1, 0, 0, 1));
        tbl.push_back(mk(1, 1, 6, 1, 0, 0,10, 1, 0, 0, 1, 0,  0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 6, 1,10, 1,11, 1, 0, 0, 0, 0,  0, 1, 2, 0, 1));

        foreach (tbl[i]) apply(tbl[i]);

        // hold for three cycles: selects stable, no issue, state frozen
        for (int k = 0; k < 3; k++)
            apply(mk(1, 1, 11, 1, 6, 1, 0, 0, 0, 0, 0, 1,  0, 0, 1, 3, 1));
        apply(mk(1, 1, 11, 1, 6, 1, 0, 0, 0, 0, 0, 0,  0, 1, 1, 3, 1));

        // load-use stall that starts under hold: held cycle is not counted
        apply(mk(1, 1, 0, 0, 0, 0, 12, 1, 1, 0, 0, 0,  0, 1, 0, 0, 1));
        apply(mk(1, 1, 12, 1, 0, 0, 0, 0, 0, 0, 0, 1,  1, 0, 0, 0, 0));
        apply(mk(1, 1, 12, 1, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0));
        apply(mk(1, 1, 12, 1, 0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 2, 0, 1));

        // reset with three live entries discards them
        apply(mk(1, 1, 0, 0, 0, 0, 13, 1, 0, 0, 0, 0,  0, 1, 0, 0, 1));
        apply(mk(1, 1, 0, 0, 0, 0, 14, 1, 0, 0, 0, 0,  0, 1, 0, 0, 1));
        apply(mk(1, 1, 0, 0, 0, 0, 15, 1, 1, 0, 0, 0,  0, 1, 0, 0, 1));
        apply(mk(0, 1, 15, 1, 14, 1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1));
        apply(mk(1, 1, 15, 1, 14, 1, 0, 0, 0, 1, 0, 0,  0, 1, 0, 0, 1));
        apply(mk(1, 1, 13, 1, 15, 1, 0, 0, 0, 0, 0, 0,  0, 1, 0, 0, 1));

        cmp("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
